// File: rtl/tw_seq_pkg.sv
// rtl/tw_seq_pkg.sv - shared types and init table for the three_wire config sequencer
package tw_seq_pkg;

    localparam int DW        = 16;
    localparam int MAX_WORDS = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_GAP,
        S_DONE
    } state_t;

    // Board-specific power-up words; entry 0 is the sync/unlock word.
    localparam logic [DW-1:0] INIT_TABLE [MAX_WORDS] = '{
        16'h55F0, 16'h1001, 16'h1002, 16'h1003,
        16'h1004, 16'h1005, 16'h1006, 16'h1007,
        16'h1008, 16'h1009, 16'h100A, 16'h100B,
        16'h100C, 16'h100D, 16'h100E, 16'h100F
    };

    function automatic logic [DW-1:0] init_word(input logic [3:0] idx);
        return INIT_TABLE[idx];
    endfunction

endpackage

// File: rtl/tw_seq_rom.sv
// rtl/tw_seq_rom.sv - combinational init-table lookup, swappable per board
import tw_seq_pkg::*;

module tw_seq_rom #(
    parameter int IW = 3
) (
    input  logic [IW-1:0] addr,
    output logic [DW-1:0] word
);

    assign word = init_word(4'(addr));

endmodule

// File: rtl/tw_config_seq.sv
// rtl/tw_config_seq.sv - init-table sequencer and host arbiter for three_wire; TW_SEQ_GAP_EN enables the inter-word gap
import tw_seq_pkg::*;

module tw_config_seq #(
    parameter int NWORDS  = 8,
    parameter int DW      = 16,
    parameter int GAP_CYC = 4,
    parameter int ACK_TO  = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   host_req,
    input  logic [DW-1:0]                          host_data,
    output logic                                   host_ack,
    output logic                                   tw_write,
    output logic [DW-1:0]                          tw_data,
    input  logic                                   tw_busy,
    output logic                                   seq_busy,
    output logic                                   init_done,
    output logic                                   err,
    output logic [((NWORDS > 1) ? $clog2(NWORDS) : 1)-1:0] word_idx
);

    localparam int IW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int CMAX = (ACK_TO > GAP_CYC) ? ACK_TO : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt, rom_addr;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   data_nxt, rom_word;
    logic            host_sel, host_sel_nxt;
    logic            done_nxt, err_nxt, word_end;

    // The ROM always presents the word that the next ISSUE would load.
    assign rom_addr = (state == S_IDLE) ? '0 : idx + IW'(1);
    assign word_idx = idx;

    tw_seq_rom #(.IW(IW)) u_rom (
        .addr (rom_addr),
        .word (rom_word)
    );

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        cnt_nxt      = cnt;
        data_nxt     = tw_data;
        host_sel_nxt = host_sel;
        done_nxt     = init_done;
        err_nxt      = err;
`ifdef TW_SEQ_GAP_EN
        word_end     = (state == S_GAP) && (cnt == '0);
`else
        word_end     = (state == S_WAIT_LO) && !tw_busy;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nxt      = '0;
                    host_sel_nxt = 1'b0;
                    data_nxt     = rom_word;
                    state_nxt    = S_ISSUE;
                end else if (host_req && init_done) begin
                    host_sel_nxt = 1'b1;
                    data_nxt     = host_data;
                    state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tw_busy) begin
                    state_nxt = S_WAIT_LO;
                end else if (cnt == CW'(ACK_TO)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WAIT_LO: begin
                if (!tw_busy) begin
                    cnt_nxt   = CW'(GAP_CYC - 1);
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt != '0) cnt_nxt = cnt - CW'(1);
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Common branch once a word's frame (and optional gap) is complete.
        if (word_end) begin
            if (host_sel) begin
                state_nxt = S_IDLE;
            end else if (idx == IW'(NWORDS - 1)) begin
                done_nxt  = 1'b1;
                state_nxt = S_DONE;
            end else begin
                idx_nxt   = idx + IW'(1);
                data_nxt  = rom_word;
                state_nxt = S_ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            host_sel  <= 1'b0;
            tw_data   <= '0;
            tw_write  <= 1'b0;
            host_ack  <= 1'b0;
            seq_busy  <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            host_sel  <= host_sel_nxt;
            tw_data   <= data_nxt;
            tw_write  <= (state == S_ISSUE);
            host_ack  <= (state == S_ISSUE) && host_sel;
            seq_busy  <= (state_nxt != S_IDLE);
            init_done <= done_nxt;
            err       <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tw_config_seq.sv
// tb/tb_tw_config_seq.sv - randomized self-checking bench for tw_config_seq
module tb_tw_config_seq;

    localparam int NWORDS  = 8;
    localparam int GAP_CYC = 4;
`ifdef TW_SEQ_GAP_EN
    localparam int GAP_EXP = GAP_CYC + 1;
`else
    localparam int GAP_EXP = 1;
`endif

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, host_req = 1'b0;
    logic [15:0] host_data = '0;
    logic        host_ack, tw_write, seq_busy, init_done, err;
    logic [15:0] tw_data;
    logic [2:0]  word_idx;
    logic        tw_busy;

    tw_config_seq dut (
        .clk(clk), .rst(rst), .start(start), .host_req(host_req),
        .host_data(host_data), .host_ack(host_ack), .tw_write(tw_write),
        .tw_data(tw_data), .tw_busy(tw_busy), .seq_busy(seq_busy),
        .init_done(init_done), .err(err), .word_idx(word_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // three_wire model: busy rises 1..3 clocks after a write, stays high for a frame
    logic busy_en = 1'b1, long_busy = 1'b0, busy_r = 1'b0;
    int   bdly = 0, blen = 0, cyc = 0;
    assign tw_busy = busy_r;

    always @(posedge clk) begin
        cyc++;
        if (bdly > 0) begin
            bdly--;
            if (bdly == 0) busy_r <= 1'b1;
        end else if (blen > 0) begin
            blen--;
            if (blen == 0) busy_r <= 1'b0;
        end
        if (tw_write && busy_en) begin
            bdly = $urandom_range(1, 3);
            blen = long_busy ? 34 : $urandom_range(3, 12);
        end
    end

    typedef struct { logic [15:0] d; logic host; logic chained; } exp_t;
    exp_t exp_q[$];
    int   n_wr = 0, n_ack = 0, fall_cyc = -1;
    logic prev_busy = 1'b0, prev_wr = 1'b0, hold_ok = 1'b0;
    logic [15:0] held;

    always @(negedge clk) begin
        exp_t e;
        if (rst) hold_ok = 1'b0;
        if (prev_busy && !tw_busy) fall_cyc = cyc;
        if (!prev_busy && tw_busy && !rst) begin hold_ok = 1'b1; held = tw_data; end
        if (hold_ok && prev_busy && tw_busy) check("data_stable", tw_data, held);
        if (host_ack) begin
            n_ack++;
            check("ack_with_write", tw_write, 1);
        end
        if (tw_write) begin
            n_wr++;
            check("write_one_cycle", prev_wr, 0);
            if (exp_q.size() == 0) check("unexpected_write", 0, 1);
            else begin
                e = exp_q.pop_front();
                check("tw_data", tw_data, e.d);
                check("ack_on_write", host_ack, e.host);
                if (e.chained) check("busy_fall_to_write", cyc - fall_cyc - 1, GAP_EXP);
            end
        end
        prev_busy = tw_busy;
        prev_wr   = tw_write;
    end

    task automatic push_table();
        for (int i = 0; i < NWORDS; i++) begin
            exp_t e;
            e.d = (i == 0) ? 16'h55F0 : 16'h1000 + 16'(i);
            e.host = 1'b0;
            e.chained = (i != 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_host(input logic [15:0] d);
        exp_t e;
        e.d = d; e.host = 1'b1; e.chained = 1'b0;
        exp_q.push_back(e);
    endtask

    // which: 0 init_done, 1 host_ack, 2 err, 3 idle, 4 tw_write, 5 busy low
    task automatic wait_sig(input int which, input int budget, input string tag);
        int n = 0;
        bit hit;
        forever begin
            case (which)
                0: hit = init_done;
                1: hit = host_ack;
                2: hit = err;
                3: hit = !seq_busy;
                4: hit = tw_write;
                default: hit = !tw_busy;
            endcase
            if (hit || n >= budget) break;
            @(negedge clk);
            n++;
        end
        if (!hit) check(tag, 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_wr = 0;
        n_ack = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [15:0] hd;
        int wc;

        repeat (3) @(negedge clk);
        check("rst_tw_write", tw_write, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_seq_busy", seq_busy, 0);
        check("rst_init_done", init_done, 0);
        check("rst_err", err, 0);
        check("rst_tw_data", tw_data, 0);
        check("rst_word_idx", word_idx, 0);
        rst = 1'b0;
        @(negedge clk);

        // full table walk, long frames
        long_busy = 1'b1;
        push_table();
        pulse_start();
        check("start_latency_write", tw_write, 0);
        check("start_seq_busy", seq_busy, 1);
        wait_sig(0, 3000, "timeout_init_done");
        check("done_after_last_fall", cyc - fall_cyc, GAP_EXP);
        check("walk_err", err, 0);
        wait_sig(3, 50, "timeout_idle_walk");
        check("walk_writes", n_wr, NWORDS);
        check("walk_queue_empty", exp_q.size(), 0);
        long_busy = 1'b0;

        // host request held across the walk
        do_reset();
        push_table();
        push_host(16'hA5A5);
        pulse_start();
        repeat ($urandom_range(2, 40)) @(negedge clk);
        host_req = 1'b1;
        host_data = 16'hA5A5;
        wait_sig(0, 2000, "timeout_init_done_host");
        check("no_ack_before_done", n_ack, 0);
        wait_sig(1, 200, "timeout_host_ack");
        host_req = 1'b0;
        wait_sig(3, 200, "timeout_idle_host");
        check("host_acks", n_ack, 1);
        check("host_queue_empty", exp_q.size(), 0);

        // start and host together: replay first, host after
        hd = 16'($urandom);
        push_table();
        push_host(hd);
        host_req = 1'b1;
        host_data = hd;
        pulse_start();
        check("replay_init_done_kept", init_done, 1);
        wait_sig(1, 2000, "timeout_replay_ack");
        host_req = 1'b0;
        wait_sig(3, 200, "timeout_idle_replay");
        check("replay_acks", n_ack, 2);
        check("replay_queue_empty", exp_q.size(), 0);

        // random host traffic
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            hd = 16'($urandom);
            push_host(hd);
            host_req = 1'b1;
            host_data = hd;
            wait_sig(1, 200, "timeout_rand_ack");
            host_req = 1'b0;
            wait_sig(3, 200, "timeout_idle_rand");
        end
        check("rand_acks", n_ack, 6);
        check("rand_queue_empty", exp_q.size(), 0);

        // busy never rises
        do_reset();
        busy_en = 1'b0;
        begin
            exp_t e;
            e.d = 16'h55F0; e.host = 1'b0; e.chained = 1'b0;
            exp_q.push_back(e);
        end
        pulse_start();
        wait_sig(4, 10, "timeout_first_write");
        wc = cyc;
        wait_sig(2, 50, "timeout_err");
        check("err_latency", cyc - wc, 9);
        repeat (10) @(negedge clk);
        check("err_seq_idle", seq_busy, 0);
        check("err_one_write", n_wr, 1);
        check("err_no_done", init_done, 0);
        busy_en = 1'b1;

        // reset during the frame of word 3
        do_reset();
        push_table();
        pulse_start();
        begin
            int n = 0;
            while (!(word_idx == 3 && tw_busy) && n < 1000) begin @(negedge clk); n++; end
            if (n >= 1000) check("timeout_word3", 0, 1);
        end
        rst = 1'b1;
        #1;
        check("mid_rst_tw_write", tw_write, 0);
        check("mid_rst_host_ack", host_ack, 0);
        check("mid_rst_seq_busy", seq_busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_tw_data", tw_data, 0);
        check("mid_rst_word_idx", word_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        n_wr = 0;
        wait_sig(5, 100, "timeout_busy_drain");
        @(negedge clk);
        push_table();
        pulse_start();
        check("restart_idx", word_idx, 0);
        wait_sig(0, 2000, "timeout_restart_done");
        wait_sig(3, 50, "timeout_idle_restart");
        check("restart_writes", n_wr, NWORDS);
        check("restart_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
